// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: bundles the uart_rx-facing and CPU-facing signals of uart_rx_fifo
//   master: drives rx_valid/rx_data/cpu_read/set_config/threshold_in, observes status
//   slave : the FIFO side; drives rx_read/cpu_data/level/empty/full/overflow/irq/rts
interface uart_rx_fifo_if #(parameter int DEPTH = 8);
  localparam int LW = $clog2(DEPTH) + 1;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_read;
  logic          cpu_read;
  logic [7:0]    cpu_data;
  logic          set_config;
  logic [LW-1:0] threshold_in;
  logic [LW-1:0] level;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          irq;
  logic          rts;
  modport master (
    output rx_valid, rx_data, cpu_read, set_config, threshold_in,
    input  rx_read, cpu_data, level, empty, full, overflow, irq, rts
  );
  modport slave (
    input  rx_valid, rx_data, cpu_read, set_config, threshold_in,
    output rx_read, cpu_data, level, empty, full, overflow, irq, rts
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead byte FIFO between a uart_rx and a CPU with level IRQ and RTS flow control
//   clk, rst : single clock, synchronous active-high reset
//   bus      : uart_rx_fifo_if.slave (rx handshake, CPU read port, config, status)
module uart_rx_fifo #(
  parameter int DEPTH = 8
) (
  input logic          clk,
  input logic          rst,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] RTS_L   = LW'(DEPTH - 2);
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q, level_d, thr_q, thr_d;
  logic          ovf_q, ovf_d, guard_q;
  logic          push, pop, accept, is_empty;
  always_comb begin
    // guard_q blocks the cycle after a pop strobe while uart_rx drops its valid
    push     = !rst && bus.rx_valid && !guard_q;
    pop      = !rst && bus.cpu_read && level_q != '0;
    accept   = push && (level_q != DEPTH_L || pop);
    level_d  = level_q + LW'(accept) - LW'(pop);
    // a rejected push beats a same-cycle clear
    ovf_d    = (push && !accept) ? 1'b1 : bus.set_config ? 1'b0 : ovf_q;
    thr_d    = !bus.set_config ? thr_q :
               bus.threshold_in == '0 ? LW'(1) :
               bus.threshold_in > DEPTH_L ? DEPTH_L : bus.threshold_in;
    is_empty = rst || level_q == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      thr_q   <= LW'(1);
      ovf_q   <= 1'b0;
      guard_q <= 1'b0;
    end else begin
      if (accept) wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      level_q <= level_d;
      thr_q   <= thr_d;
      ovf_q   <= ovf_d;
      guard_q <= push;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) mem_q[wptr_q] <= bus.rx_data;
  end
  // status outputs are forced to their reset values for the whole reset cycle
  assign bus.rx_read  = push;
  assign bus.cpu_data = is_empty ? 8'h00 : mem_q[rptr_q];
  assign bus.level    = rst ? '0 : level_q;
  assign bus.empty    = is_empty;
  assign bus.full     = !rst && level_q == DEPTH_L;
  assign bus.overflow = !rst && ovf_q;
  assign bus.irq      = !rst && (level_q >= thr_q || ovf_q);
  assign bus.rts      = !rst && level_q >= RTS_L;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized checks of uart_rx_fifo against a queue-based model
module tb_uart_rx_fifo;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus();
  uart_rx_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  byte unsigned q[$];
  bit m_ovf, m_guard, last_rr;
  int m_thr = 1;
  int checks = 0;
  int errors = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask
  function automatic bit exp_rr();
    return !rst && bus.rx_valid && !m_guard;
  endfunction
  task automatic check_outputs();
    int lvl;
    lvl = rst ? 0 : q.size();
    chk("rx_read", bus.rx_read, exp_rr());
    chk("level", bus.level, lvl);
    chk("empty", bus.empty, lvl == 0);
    chk("full", bus.full, lvl == DEPTH);
    chk("overflow", bus.overflow, !rst && m_ovf);
    chk("irq", bus.irq, !rst && (lvl >= m_thr || m_ovf));
    chk("rts", bus.rts, !rst && lvl >= DEPTH - 2);
    chk("cpu_data", bus.cpu_data, lvl == 0 ? 0 : q[0]);
  endtask
  task automatic step();
    bit rr, pop, rej;
    #4;
    rr = exp_rr();
    last_rr = rr;
    check_outputs();
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ovf = 0;
      m_thr = 1;
      m_guard = 0;
    end else begin
      pop = bus.cpu_read && q.size() > 0;
      rej = rr && q.size() == DEPTH && !pop;
      if (pop) void'(q.pop_front());
      if (rr && !rej) q.push_back(bus.rx_data);
      if (rej) m_ovf = 1;
      else if (bus.set_config) m_ovf = 0;
      if (bus.set_config)
        m_thr = bus.threshold_in == 0 ? 1 : bus.threshold_in > DEPTH ? DEPTH : int'(bus.threshold_in);
      m_guard = rr;
    end
    #1;
  endtask
  task automatic idle();
    bus.rx_valid = 0;
    bus.rx_data = 0;
    bus.cpu_read = 0;
    bus.set_config = 0;
    bus.threshold_in = 0;
  endtask
  task automatic push_byte(input logic [7:0] b);
    bus.rx_valid = 1;
    bus.rx_data = b;
    step();
    bus.rx_valid = 0;
    step();
  endtask
  task automatic pop_one();
    bus.cpu_read = 1;
    step();
    bus.cpu_read = 0;
  endtask
  task automatic configure(input int t);
    bus.set_config = 1;
    bus.threshold_in = 4'(t);
    step();
    bus.set_config = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
  endtask
  initial begin
    logic [3:0] pat;
    logic [7:0] exp_b [3];
    rst = 1;
    idle();
    step();
    step();
    chk("rst_empty", bus.empty, 1);
    chk("rst_irq", bus.irq, 0);
    rst = 0;
    step();
    // three single-pulse pushes, read back in order
    push_byte(8'h41);
    push_byte(8'h42);
    push_byte(8'h43);
    chk("lvl3", bus.level, 3);
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
    for (int i = 0; i < 3; i++) begin
      chk("head", bus.cpu_data, exp_b[i]);
      pop_one();
    end
    chk("drained_empty", bus.empty, 1);
    chk("drained_data", bus.cpu_data, 8'h00);
    // rx_valid held four cycles: strobes on cycles 1 and 3
    bus.rx_valid = 1;
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      bus.rx_data = 8'h10 + 8'(i);
      step();
      pat = {pat[2:0], last_rr};
    end
    bus.rx_valid = 0;
    chk("rx_read_pattern", pat, 4'b1010);
    chk("held_two_pushes", bus.level, 2);
    chk("held_first", bus.cpu_data, 8'h10);
    // fill to full, then overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      push_byte(8'h80 + 8'(i));
      chk("rts_fill", bus.rts, i + 1 >= DEPTH - 2);
    end
    chk("full", bus.full, 1);
    push_byte(8'hEE);
    chk("ovf_set", bus.overflow, 1);
    chk("ovf_irq", bus.irq, 1);
    chk("ovf_level", bus.level, DEPTH);
    // clear overflow, then push+pop on a full FIFO
    configure(DEPTH);
    chk("ovf_clear", bus.overflow, 0);
    bus.rx_valid = 1;
    bus.rx_data = 8'h99;
    bus.cpu_read = 1;
    step();
    idle();
    step();
    chk("full_pushpop_lvl", bus.level, DEPTH);
    chk("full_pushpop_ovf", bus.overflow, 0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("last_0x99", bus.cpu_data, 8'h99);
      pop_one();
    end
    // threshold behaviour
    configure(3);
    push_byte(8'h01);
    push_byte(8'h02);
    chk("irq_lvl2", bus.irq, 0);
    push_byte(8'h03);
    chk("irq_lvl3", bus.irq, 1);
    pop_one();
    pop_one();
    chk("irq_lvl1_thr3", bus.irq, 0);
    configure(0);
    chk("irq_lvl1_thr0", bus.irq, 1);
    // wrap-around and mid-stream reset
    do_reset();
    for (int i = 0; i < 5; i++) push_byte(8'hA0 + 8'(i));
    for (int i = 0; i < 3; i++) pop_one();
    for (int i = 0; i < 6; i++) push_byte(8'hB0 + 8'(i));
    chk("wrap_level", bus.level, DEPTH);
    chk("wrap_head", bus.cpu_data, 8'hA3);
    pop_one();
    pop_one();
    chk("wrap_order", bus.cpu_data, 8'hB0);
    push_byte(8'hC0);
    rst = 1;
    step();
    rst = 0;
    chk("rst_mid_level", bus.level, 0);
    chk("rst_mid_empty", bus.empty, 1);
    chk("rst_mid_ovf", bus.overflow, 0);
    // randomized traffic, alternating fill-biased and drain-biased phases
    for (int c = 0; c < 3000; c++) begin
      bit fill;
      fill = ((c / 300) % 2) == 0;
      rst = ($urandom_range(0, 499) == 0);
      bus.rx_valid = ($urandom_range(0, 3) != 0);
      bus.rx_data = 8'($urandom);
      bus.cpu_read = fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      bus.set_config = ($urandom_range(0, 39) == 0);
      bus.threshold_in = 4'($urandom_range(0, 15));
      step();
    end
    rst = 0;
    idle();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 4..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rx_valid  input  1  uart_rx holds a received byte.
REQ-005 SHALL have port rx_data  input  8  received byte from uart_rx.
REQ-006 SHALL have port rx_read  output  1  one-cycle pop strobe to uart_rx (drives its uart_rx_read).
REQ-007 SHALL have port cpu_read  input  1  CPU data read strobe; pops head entry.
REQ-008 SHALL have port cpu_data  output  8  head entry (show-ahead).
REQ-009 SHALL have port set_config  input  1  load threshold_in and clear overflow.
REQ-010 SHALL have port threshold_in  input  $clog2(DEPTH)+1  IRQ level threshold.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  current entry count.
REQ-012 SHALL have port empty  output  1  level == 0.
REQ-013 SHALL have port full  output  1  level == DEPTH.
REQ-014 SHALL have port overflow  output  1  sticky: byte dropped while full.
REQ-015 SHALL have port irq  output  1  level >= threshold, or overflow.
REQ-016 SHALL have port rts  output  1  high = request sender stop.

Function
REQ-017 SHALL assert rx_read combinationally when rx_valid=1 and rx_read was 0 in the previous cycle (guard cycle while uart_rx clears valid).
REQ-018 SHALL treat a cycle with rx_read=1 as a push attempt, capturing rx_data that cycle.
REQ-019 SHALL accept a push when !full, or when full and a pop occurs in the same cycle.
REQ-020 SHALL discard a rejected push and set overflow; FIFO contents and level unchanged.
REQ-021 SHALL pop on cpu_read=1 when !empty; cpu_read on empty SHALL have no effect.
REQ-022 SHALL, on simultaneous push and pop with level==0, accept push only (level 0 -> 1).
REQ-023 SHALL, on simultaneous push and pop with 0<level<=DEPTH, do both; level unchanged.
REQ-024 SHALL present cpu_data = head entry when !empty, 8'h00 when empty; new head visible the cycle after a pop.
REQ-025 SHALL make a pushed byte visible on cpu_data one cycle after push (level updated same edge).
REQ-026 SHALL use wrapping read/write pointers of $clog2(DEPTH) bits; level = separate counter, 0..DEPTH.
REQ-027 SHALL preserve byte order across pointer wrap-around.
REQ-028 SHALL, on set_config, load threshold; value 0 SHALL be stored as 1, values > DEPTH as DEPTH.
REQ-029 SHALL, on set_config, clear overflow; a rejected push in the same cycle SHALL win (overflow stays 1).
REQ-030 SHALL drive irq = (level >= threshold) | overflow, registered-free from state (combinational from registers).
REQ-031 SHALL drive rts = 1 when level >= DEPTH-2, else 0.
REQ-032 SHALL keep overflow set until set_config or reset.

Reset
REQ-033 SHALL, while rst=1, force level=0, pointers=0, overflow=0, threshold=1, guard flag=0.
REQ-034 SHALL, while rst=1, drive rx_read=0, cpu_data=8'h00, empty=1, full=0, irq=0, rts=0.
REQ-035 SHALL discard all stored bytes when rst asserts mid-operation; no push or pop occurs in a reset cycle.
REQ-036 SHALL ignore rx_valid, cpu_read and set_config while rst=1.

Verification
REQ-037 SHALL verify: push 0x41,0x42,0x43 (rx_valid pulses) -> level=3, reads return 0x41,0x42,0x43, then empty=1, cpu_data=0x00.
REQ-038 SHALL verify: rx_valid held high 4 cycles -> rx_read pulses on cycles 1 and 3 only, two pushes.
REQ-039 SHALL verify: DEPTH=8, push 8 bytes -> full=1, rts=1 from level 6; ninth push -> dropped, overflow=1, irq=1, level=8.
REQ-040 SHALL verify: full FIFO, push 0x99 with simultaneous cpu_read -> level stays 8, 0x99 read last, overflow=0.
REQ-041 SHALL verify: threshold_in=3 -> irq=0 at level 2, irq=1 at level 3; set_config with threshold_in=0 -> irq=1 at level 1.
REQ-042 SHALL verify: 5 bytes stored, 3 read, 6 pushed (pointer wrap), rst pulse mid-stream -> level=0, empty=1, overflow=0 next cycle.
